reg_f_arb: RTL and testbench

- Two-requester arbiter and access sequencer in front of reg_f; requesters are the core datapath (A) and the debug/DMA loader (B).
- Grants one requester per cycle and drives reg_f SEL/IN/EN from it.
- Captures read data from reg_f OUT and returns it with a done pulse.
- Supports locked bursts, bounded by MAX_BURST, so neither side starves.

---
 rtl/reg_f_arb.sv | 145 ++++++++++++++
 tb/tb_reg_f_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_f_arb.sv
// Two-requester arbiter and access sequencer in front of reg_f.
// Core datapath (A) and debug/DMA loader (B) share one register-file port with bounded locked bursts.
module reg_f_arb #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SIZE      = 9,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     A_REQ,
    input  logic                     A_WE,
    input  logic                     A_LOCK,
    input  logic [$clog2(SIZE)-1:0]  A_SEL,
    input  logic [WIDTH-1:0]         A_DATA,
    output logic                     A_GNT,
    output logic                     A_DONE,
    output logic [WIDTH-1:0]         A_RDATA,
    input  logic                     B_REQ,
    input  logic                     B_WE,
    input  logic                     B_LOCK,
    input  logic [$clog2(SIZE)-1:0]  B_SEL,
    input  logic [WIDTH-1:0]         B_DATA,
    output logic                     B_GNT,
    output logic                     B_DONE,
    output logic [WIDTH-1:0]         B_RDATA,
    output logic                     RF_EN,
    output logic [$clog2(SIZE)-1:0]  RF_SEL,
    output logic [WIDTH-1:0]         RF_IN,
    input  logic [WIDTH-1:0]         RF_OUT
);

    localparam int unsigned SW = $clog2(SIZE);
    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             ptr_b_q, ptr_b_d;   // 1: B wins the next contested grant from IDLE
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             a_done_q, a_done_d;
    logic             b_done_q, b_done_d;
    logic [WIDTH-1:0] a_rdata_q, a_rdata_d;
    logic [WIDTH-1:0] b_rdata_q, b_rdata_d;

    logic             rf_en_c;
    logic [SW-1:0]    rf_sel_c;
    logic [WIDTH-1:0] rf_in_c;
    logic             both_c;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_b_q   <= 1'b0;
            cnt_q     <= '0;
            a_done_q  <= 1'b0;
            b_done_q  <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_b_q   <= ptr_b_d;
            cnt_q     <= cnt_d;
            a_done_q  <= a_done_d;
            b_done_q  <= b_done_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Port mux, access completion and next-owner arbitration
    always_comb begin
        state_d   = state_q;
        ptr_b_d   = ptr_b_q;
        cnt_d     = cnt_q;
        a_done_d  = 1'b0;
        b_done_d  = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        rf_en_c   = 1'b0;
        rf_sel_c  = '0;
        rf_in_c   = '0;
        both_c    = A_REQ & B_REQ;

        case (state_q)
            OWN_A: begin
                rf_sel_c = A_SEL;
                rf_in_c  = A_DATA;
                rf_en_c  = A_WE & A_REQ;
                if (A_REQ) begin
                    a_done_d = 1'b1;
                    if (!A_WE) a_rdata_d = RF_OUT;
                end
            end
            OWN_B: begin
                rf_sel_c = B_SEL;
                rf_in_c  = B_DATA;
                rf_en_c  = B_WE & B_REQ;
                if (B_REQ) begin
                    b_done_d = 1'b1;
                    if (!B_WE) b_rdata_d = RF_OUT;
                end
            end
            default: ;
        endcase

        if (!A_REQ && !B_REQ) begin
            state_d = IDLE;
        end else if (!B_REQ) begin
            state_d = OWN_A;
        end else if (!A_REQ) begin
            state_d = OWN_B;
        end else begin
            case (state_q)
                OWN_A:   state_d = (A_LOCK && cnt_q < CW'(MAX_BURST)) ? OWN_A : OWN_B;
                OWN_B:   state_d = (B_LOCK && cnt_q < CW'(MAX_BURST)) ? OWN_B : OWN_A;
                default: state_d = ptr_b_q ? OWN_B : OWN_A;
            endcase
        end

        // Burst length only advances under contention; an uncontested owner holds freely
        if (state_d != IDLE) begin
            if (state_d != state_q) begin
                cnt_d = CW'(1);
            end else if (both_c) begin
                cnt_d = cnt_q + CW'(1);
            end
            ptr_b_d = (state_d == OWN_A);
        end
    end

    assign A_GNT   = (state_q == OWN_A);
    assign B_GNT   = (state_q == OWN_B);
    assign A_DONE  = a_done_q;
    assign B_DONE  = b_done_q;
    assign A_RDATA = a_rdata_q;
    assign B_RDATA = b_rdata_q;
    assign RF_EN   = rf_en_c;
    assign RF_SEL  = rf_sel_c;
    assign RF_IN   = rf_in_c;

endmodule

// File: tb/tb_reg_f_arb.sv
// Randomized bench for reg_f_arb against a transaction-level arbitration model and a local reg_f.
module tb_reg_f_arb;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned SIZE  = 9;
    localparam int unsigned MAXB  = 4;
    localparam int unsigned SW    = $clog2(SIZE);

    logic             CLK = 1'b0;
    logic             RST;
    logic             A_REQ, A_WE, A_LOCK, B_REQ, B_WE, B_LOCK;
    logic [SW-1:0]    A_SEL, B_SEL;
    logic [WIDTH-1:0] A_DATA, B_DATA;
    logic             A_GNT, A_DONE, B_GNT, B_DONE, RF_EN;
    logic [WIDTH-1:0] A_RDATA, B_RDATA, RF_IN, RF_OUT;
    logic [SW-1:0]    RF_SEL;

    reg_f_arb #(.WIDTH(WIDTH), .SIZE(SIZE), .MAX_BURST(MAXB)) dut (
        .CLK(CLK), .RST(RST),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_LOCK(A_LOCK), .A_SEL(A_SEL), .A_DATA(A_DATA),
        .A_GNT(A_GNT), .A_DONE(A_DONE), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_LOCK(B_LOCK), .B_SEL(B_SEL), .B_DATA(B_DATA),
        .B_GNT(B_GNT), .B_DONE(B_DONE), .B_RDATA(B_RDATA),
        .RF_EN(RF_EN), .RF_SEL(RF_SEL), .RF_IN(RF_IN), .RF_OUT(RF_OUT)
    );

    always #5 CLK = ~CLK;

    // Stand-in register file: every select slot is storage so all writes are observable
    logic [WIDTH-1:0] rf_mem [16] = '{default: '0};
    assign RF_OUT = rf_mem[RF_SEL];
    always @(posedge CLK) if (RF_EN) rf_mem[RF_SEL] <= RF_IN;

    // Reference model: owner 0=none 1=A 2=B
    int               m_own, m_ptr, m_cnt;
    logic [WIDTH-1:0] m_mem [16] = '{default: '0};
    logic [WIDTH-1:0] m_a_rdata, m_b_rdata;
    bit               m_a_done, m_b_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_ptr = 1; m_cnt = 0;
        m_a_rdata = '0; m_b_rdata = '0;
        m_a_done = 0; m_b_done = 0;
    endtask

    task automatic model_step();
        int nxt;
        m_a_done = 0;
        m_b_done = 0;
        if (m_own == 1 && A_REQ) begin
            m_a_done = 1;
            if (A_WE) m_mem[A_SEL] = A_DATA; else m_a_rdata = m_mem[A_SEL];
        end
        if (m_own == 2 && B_REQ) begin
            m_b_done = 1;
            if (B_WE) m_mem[B_SEL] = B_DATA; else m_b_rdata = m_mem[B_SEL];
        end
        if (!A_REQ && !B_REQ)    nxt = 0;
        else if (!B_REQ)         nxt = 1;
        else if (!A_REQ)         nxt = 2;
        else if (m_own == 0)     nxt = m_ptr;
        else if (((m_own == 1) ? A_LOCK : B_LOCK) && m_cnt < int'(MAXB)) nxt = m_own;
        else                     nxt = 3 - m_own;
        if (nxt != 0) begin
            if (nxt != m_own)            m_cnt = 1;
            else if (A_REQ && B_REQ)     m_cnt = m_cnt + 1;
            m_ptr = 3 - nxt;
        end
        m_own = nxt;
    endtask

    task automatic check_outputs();
        logic             e_en;
        logic [SW-1:0]    e_sel;
        logic [WIDTH-1:0] e_in;
        e_en = 1'b0; e_sel = '0; e_in = '0;
        if (m_own == 1) begin e_en = A_WE & A_REQ; e_sel = A_SEL; e_in = A_DATA; end
        if (m_own == 2) begin e_en = B_WE & B_REQ; e_sel = B_SEL; e_in = B_DATA; end
        check("a_gnt",   32'(A_GNT),   32'(m_own == 1));
        check("b_gnt",   32'(B_GNT),   32'(m_own == 2));
        check("a_done",  32'(A_DONE),  32'(m_a_done));
        check("b_done",  32'(B_DONE),  32'(m_b_done));
        check("a_rdata", 32'(A_RDATA), 32'(m_a_rdata));
        check("b_rdata", 32'(B_RDATA), 32'(m_b_rdata));
        check("rf_en",   32'(RF_EN),   32'(e_en));
        check("rf_sel",  32'(RF_SEL),  32'(e_sel));
        check("rf_in",   32'(RF_IN),   32'(e_in));
    endtask

    task automatic run_cycle();
        @(negedge CLK);
        check_outputs();
        @(posedge CLK);
        model_step();
        cyc++;
        #1;
    endtask

    // Async reset asserted between edges while the current inputs are still applied
    task automatic mid_reset();
        @(negedge CLK);
        check_outputs();
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge CLK);
        cyc++;
        #1 RST = 1'b0;
    endtask

    task automatic set_in(input logic ar, input logic aw, input logic al, input logic [SW-1:0] as,
                          input logic [WIDTH-1:0] ad, input logic br, input logic bw, input logic bl,
                          input logic [SW-1:0] bs, input logic [WIDTH-1:0] bd);
        A_REQ = ar; A_WE = aw; A_LOCK = al; A_SEL = as; A_DATA = ad;
        B_REQ = br; B_WE = bw; B_LOCK = bl; B_SEL = bs; B_DATA = bd;
    endtask

    task automatic rand_in(input int unsigned lock_pct);
        A_REQ  = ($urandom_range(0, 99) < 75);
        B_REQ  = ($urandom_range(0, 99) < 75);
        A_WE   = 1'($urandom);
        B_WE   = 1'($urandom);
        A_LOCK = ($urandom_range(0, 99) < lock_pct);
        B_LOCK = ($urandom_range(0, 99) < lock_pct);
        A_SEL  = SW'($urandom);
        B_SEL  = SW'($urandom);
        A_DATA = WIDTH'($urandom);
        B_DATA = WIDTH'($urandom);
    endtask

    initial begin
        RST = 1'b1;
        set_in(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_outputs();
        @(posedge CLK);
        #1 RST = 1'b0;

        // A writes R3=AB, then reads it back
        set_in(1, 1, 0, SW'(3), 8'hAB, 0, 0, 0, '0, '0);
        repeat (2) run_cycle();
        set_in(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (2) run_cycle();
        set_in(1, 0, 0, SW'(3), '0, 0, 0, 0, '0, '0);
        repeat (2) run_cycle();
        set_in(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (2) run_cycle();
        check("r3_rdata", 32'(A_RDATA), 32'h000000AB);

        // Contested unlocked requests right after reset alternate starting with A
        mid_reset();
        set_in(1, 0, 0, SW'(3), '0, 1, 1, 0, SW'(6), 8'h5A);
        repeat (8) run_cycle();

        // A locked under contention: bursts bounded at MAX_BURST
        set_in(1, 1, 1, SW'(1), 8'h31, 1, 0, 0, SW'(6), '0);
        repeat (14) run_cycle();
        set_in(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (2) run_cycle();

        // A drops REQ during its granted cycle: no write, no DONE
        set_in(1, 1, 0, SW'(5), 8'h11, 0, 0, 0, '0, '0);
        run_cycle();
        set_in(0, 1, 0, SW'(5), 8'hDC, 0, 0, 0, '0, '0);
        repeat (3) run_cycle();
        check("r5_untouched", 32'(rf_mem[5]), 32'h0);

        // Reset in the middle of a locked burst, then contested restart
        set_in(1, 1, 1, SW'(2), 8'h77, 1, 1, 0, SW'(4), 8'h88);
        repeat (3) run_cycle();
        mid_reset();
        repeat (3) run_cycle();

        for (int i = 0; i < 900; i++) begin
            rand_in((i < 450) ? 20 : 85);
            if (i % 97 == 50) mid_reset(); else run_cycle();
        end

        set_in(0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        repeat (2) run_cycle();
        for (int k = 0; k < 16; k++) check("rf_mem", 32'(rf_mem[k]), 32'(m_mem[k]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
